// File: rtl/exec_step_sequencer.sv
// Front-panel execution controller: debounced NEXT/RUN/FAST/HALT buttons drive
// an IDLE/RUN_SLOW/RUN_FAST sequencer that issues paced, handshaked step strobes.
module exec_step_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SLOW_DIV        = 50000000,
  parameter int unsigned FAST_DIV        = 500000,
  parameter int unsigned TMR_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_run,
  input  logic       btn_fast,
  input  logic       btn_halt,
  input  logic       step_ready,
  output logic       step_pulse,
  output logic [1:0] state,
  output logic       running,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SLOW = 2'b01;
  localparam logic [1:0] ST_FAST = 2'b10;

  localparam logic [CW-1:0]    DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SLOW_LAST = TMR_W'(SLOW_DIV - 1);
  localparam logic [TMR_W-1:0] FAST_LAST = TMR_W'(FAST_DIV - 1);

  // Bit order: 0 next, 1 run, 2 fast, 3 halt
  logic [3:0] btn_raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] lvl;
  logic [3:0] lvl_q;
  logic [3:0] ev;

  assign btn_raw = {btn_halt, btn_fast, btn_run, btn_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl_q <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      lvl_q <= lvl;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          lvl_b;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        lvl_b <= 1'b0;
      end else if (sync2[i] == lvl_b) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt   <= '0;
        lvl_b <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign lvl[i] = lvl_b;
  end

  assign ev = lvl & ~lvl_q;

  logic ev_next;
  logic ev_run;
  logic ev_fast;
  logic ev_halt;

  assign ev_next = ev[0];
  assign ev_run  = ev[1];
  assign ev_fast = ev[2];
  assign ev_halt = ev[3];

  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] div_last;
  logic             pending;
  logic             enter;
  logic             run_st;
  logic             tick;
  logic             next_req;
  logic             issue;

  assign enter    = ev_halt | ev_fast | ev_run;
  assign run_st   = (state != ST_IDLE);
  assign div_last = (state == ST_FAST) ? FAST_LAST : SLOW_LAST;
  // A mode change restarts pacing, so a coincident tick is discarded
  assign tick     = run_st & ~enter & (timer == div_last);
  assign next_req = ev_next & ~enter & (state == ST_IDLE);
  assign issue    = pending & step_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (ev_halt) begin
        state <= ST_IDLE;
      end else if (ev_fast) begin
        state <= ST_FAST;
      end else if (ev_run) begin
        state <= ST_SLOW;
      end

      if (enter || !run_st || tick) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (ev_halt) begin
        pending <= 1'b0;
      end else if (tick || next_req) begin
        pending <= 1'b1;
      end else if (issue) begin
        pending <= 1'b0;
      end

      // A tick is only lost when the previous step is still stuck
      if (ev_halt) begin
        overrun <= 1'b0;
      end else if (tick && pending && !step_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  assign step_pulse = issue;
  assign running    = run_st;

endmodule
